// File: rtl/fir_coef_loader_if.sv
// Configuration bus between the coefficient loader (master) and the FIR filter (slave):
// coefficient write/readback, result-shift write/readback and the delay-line flush strobe.
interface fir_coef_loader_if #(
    parameter int coef_width  = 24,
    parameter int coef_count  = 16,
    parameter int max_shift   = 32,
    parameter int coef_id_w   = $clog2(coef_count),
    parameter int max_shift_w = $clog2(max_shift)
);
    logic [coef_id_w-1:0]   addr;
    logic [coef_width-1:0]  coef;
    logic                   coef_ready;
    logic                   coef_done;
    logic [coef_width-1:0]  coef_r;
    logic                   result_shift_ready;
    logic [max_shift_w-1:0] result_shift_i;
    logic                   result_shift_done;
    logic [max_shift_w-1:0] result_shift;
    logic                   flush;

    modport master (
        output addr, coef, coef_ready, result_shift_ready, result_shift_i, flush,
        input  coef_done, coef_r, result_shift_done, result_shift
    );

    modport slave (
        input  addr, coef, coef_ready, result_shift_ready, result_shift_i, flush,
        output coef_done, coef_r, result_shift_done, result_shift
    );
endinterface

// File: rtl/fir_coef_loader.sv
// Loads coef_count host words into the FIR filter with write/readback verification,
// then programs and verifies the result shift and flushes the delay lines.
module fir_coef_loader #(
    parameter int coef_width  = 24,
    parameter int coef_count  = 16,
    parameter int max_shift   = 32,
    parameter int timeout     = 15,
    localparam int coef_id_w   = $clog2(coef_count),
    localparam int max_shift_w = $clog2(max_shift)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [max_shift_w-1:0] shift_val,
    input  logic                   src_valid,
    input  logic [coef_width-1:0]  src_data,
    output logic                   src_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [1:0]             err_code,
    output logic [coef_id_w-1:0]   err_addr,
    output logic [2:0]             dbg_state,
    fir_coef_loader_if.master      bus
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_WRITE    = 3'd2;
    localparam logic [2:0] S_READ     = 3'd3;
    localparam logic [2:0] S_CMP      = 3'd4;
    localparam logic [2:0] S_SHIFT_WR = 3'd5;
    localparam logic [2:0] S_FLUSH    = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_COEF    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_SHIFT   = 2'b11;

    localparam int tcnt_w = $clog2(timeout + 1);
    localparam logic [tcnt_w-1:0]    tcnt_last = tcnt_w'(timeout - 1);
    localparam logic [coef_id_w-1:0] last_addr = coef_id_w'(coef_count - 1);

    logic [2:0]             state, state_d;
    logic [coef_id_w-1:0]   addr_q;
    logic [coef_width-1:0]  coef_q;
    logic [max_shift_w-1:0] shift_q;
    logic [tcnt_w-1:0]      tcnt;
    logic                   error_q;
    logic [1:0]             err_code_q;
    logic [coef_id_w-1:0]   err_addr_q;

    logic start_acc;
    logic write_ack;
    logic tmo;
    logic coef_bad;
    logic shift_bad;
    logic is_last;
    logic tcnt_clr;
    logic err_set;
    logic [1:0]           err_code_d;
    logic [coef_id_w-1:0] err_addr_d;

    // Host stream: a word moves only on a cycle where src_valid and src_ready are both
    // high; src_data must be stable while src_valid is high and src_ready is low.
    assign start_acc = (state == S_IDLE) && start;
    // The filter needs coef_ready for at least two cycles, so an ack in the first is ignored.
    assign write_ack = bus.coef_done && (tcnt != '0);
    assign tmo       = (tcnt == tcnt_last);
    assign coef_bad  = (bus.coef_r != coef_q);
    assign shift_bad = (bus.result_shift != shift_q);
    assign is_last   = (addr_q == last_addr);

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:     if (start) state_d = S_FETCH;
            S_FETCH:    if (src_valid) state_d = S_WRITE;
            S_WRITE: begin
                if (write_ack)  state_d = S_READ;
                else if (tmo)   state_d = S_DONE;
            end
            S_READ:     state_d = S_CMP;
            S_CMP: begin
                if (coef_bad)     state_d = S_DONE;
                else if (is_last) state_d = S_SHIFT_WR;
                else              state_d = S_FETCH;
            end
            S_SHIFT_WR: begin
                if (bus.result_shift_done) state_d = shift_bad ? S_DONE : S_FLUSH;
                else if (tmo)              state_d = S_DONE;
            end
            S_FLUSH:    state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        err_set    = 1'b0;
        err_code_d = ERR_NONE;
        err_addr_d = addr_q;
        case (state)
            S_WRITE: begin
                if (!write_ack && tmo) begin
                    err_set    = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end
            end
            S_CMP: begin
                if (coef_bad) begin
                    err_set    = 1'b1;
                    err_code_d = ERR_COEF;
                end
            end
            S_SHIFT_WR: begin
                if (bus.result_shift_done && shift_bad) begin
                    err_set    = 1'b1;
                    err_code_d = ERR_SHIFT;
                    err_addr_d = last_addr;
                end else if (!bus.result_shift_done && tmo) begin
                    err_set    = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    err_addr_d = last_addr;
                end
            end
            default: ;
        endcase
    end

    // The ack-wait counter restarts whenever WRITE or SHIFT_WR is entered.
    assign tcnt_clr = ((state_d == S_WRITE)    && (state != S_WRITE)) ||
                      ((state_d == S_SHIFT_WR) && (state != S_SHIFT_WR));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            coef_q     <= '0;
            shift_q    <= '0;
            tcnt       <= '0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            err_addr_q <= '0;
        end else begin
            state <= state_d;

            if (start_acc) begin
                shift_q <= shift_val;
                addr_q  <= '0;
            end else if ((state == S_CMP) && !coef_bad && !is_last) begin
                addr_q <= addr_q + 1'b1;
            end

            if ((state == S_FETCH) && src_valid) coef_q <= src_data;

            if (tcnt_clr) tcnt <= '0;
            else if ((state == S_WRITE) || (state == S_SHIFT_WR)) tcnt <= tcnt + 1'b1;

            if (start_acc) begin
                error_q    <= 1'b0;
                err_code_q <= ERR_NONE;
                err_addr_q <= '0;
            end else if (err_set) begin
                error_q    <= 1'b1;
                err_code_q <= err_code_d;
                err_addr_q <= err_addr_d;
            end
        end
    end

    // Strobes decode from one state each, so they can never overlap.
    assign src_ready              = (state == S_FETCH);
    assign bus.coef_ready         = (state == S_WRITE);
    assign bus.result_shift_ready = (state == S_SHIFT_WR);
    assign bus.flush              = (state == S_FLUSH);
    assign bus.addr               = addr_q;
    assign bus.coef               = coef_q;
    assign bus.result_shift_i     = shift_q;
    assign busy                   = (state != S_IDLE);
    assign done                   = (state == S_DONE);
    assign error                  = error_q;
    assign err_code               = err_code_q;
    assign err_addr               = err_addr_q;
    assign dbg_state              = state;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader with a behavioural filter model that can inject
// readback faults, missing acks and a wrong result-shift readout.
module tb_fir_coef_loader;
  localparam int coef_width  = 24;
  localparam int coef_count  = 16;
  localparam int max_shift   = 32;
  localparam int timeout     = 15;
  localparam int coef_id_w   = 4;
  localparam int max_shift_w = 5;
  localparam int rec_w       = coef_id_w + coef_width;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [max_shift_w-1:0] shift_val;
  logic                   src_valid;
  logic [coef_width-1:0]  src_data;
  logic                   src_ready;
  logic                   busy;
  logic                   done;
  logic                   error;
  logic [1:0]             err_code;
  logic [coef_id_w-1:0]   err_addr;
  logic [2:0]             dbg_state;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fir_coef_loader_if #(.coef_width(coef_width), .coef_count(coef_count), .max_shift(max_shift)) bus ();

  fir_coef_loader #(.coef_width(coef_width), .coef_count(coef_count), .max_shift(max_shift), .timeout(timeout)) dut (
    .clk(clk), .rst(rst), .start(start), .shift_val(shift_val),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .err_addr(err_addr),
    .dbg_state(dbg_state), .bus(bus.master)
  );

  // ---------------- filter model ----------------
  int bad_addr = -1;
  int noack_addr = -1;
  bit shift_corrupt = 1'b0;
  logic [max_shift_w-1:0] shift_corrupt_val = '0;
  logic [coef_width-1:0] mem [coef_count];

  always @(posedge clk) begin
    if (rst) begin
      bus.coef_done         <= 1'b0;
      bus.coef_r            <= '0;
      bus.result_shift_done <= 1'b0;
      bus.result_shift      <= '0;
    end else begin
      bus.coef_done <= 1'b0;
      if (bus.coef_ready && !bus.coef_done && int'(bus.addr) != noack_addr) begin
        mem[bus.addr] <= bus.coef;
        bus.coef_done <= 1'b1;
      end
      if (!bus.coef_ready) bus.coef_r <= (int'(bus.addr) == bad_addr) ? '0 : mem[bus.addr];
      bus.result_shift_done <= 1'b0;
      if (bus.result_shift_ready && !bus.result_shift_done) begin
        bus.result_shift      <= shift_corrupt ? shift_corrupt_val : bus.result_shift_i;
        bus.result_shift_done <= 1'b1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [rec_w-1:0] exp_q[$];
  logic [rec_w-1:0] obs_q[$];

  int n_ready, n_flush, n_done, n_rs, overlap, max_run, busy_cyc;
  bit got_done;
  logic err_first;
  logic [max_shift_w-1:0] rs_seen;

  // ---------------- driver ----------------
  // Runs one sequence from a negedge in IDLE until the done pulse, collecting activity.
  task automatic run_seq(input logic [max_shift_w-1:0] sv, input int stall_at, input int stall_len,
                         input int restart_at);
    int word_idx;
    int stalled;
    int run;
    int cyc;
    bit xfer;
    word_idx = 0; stalled = 0; run = 0; cyc = 0; xfer = 1'b0;
    obs_q.delete();
    n_ready = 0; n_flush = 0; n_done = 0; n_rs = 0; overlap = 0; max_run = 0; busy_cyc = 0;
    got_done = 1'b0; rs_seen = '0; err_first = 1'b1;
    start = 1'b1; shift_val = sv; src_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (!got_done && cyc < 400) begin
      if (cyc == 0) err_first = error;
      if (xfer) word_idx++;
      if (word_idx == stall_at && stalled < stall_len && (stalled > 0 || src_ready)) begin
        src_valid = 1'b0;
        stalled++;
        vectors++; if (src_ready !== 1'b1) begin miscompares++; $display("FAIL stall_src_ready: got %0b expected 1", src_ready); end
        vectors++; if (bus.addr !== coef_id_w'(stall_at)) begin miscompares++; $display("FAIL stall_addr: got %0d expected %0d", bus.addr, stall_at); end
        vectors++; if (bus.coef_ready !== 1'b0) begin miscompares++; $display("FAIL stall_coef_ready: got %0b expected 0", bus.coef_ready); end
      end else begin
        src_valid = (word_idx < coef_count);
      end
      src_data = coef_width'(word_idx * 3);
      if (cyc == restart_at) begin start = 1'b1; shift_val = 5'd9; end else start = 1'b0;
      if (busy) busy_cyc++;
      if (bus.coef_ready) begin n_ready++; run++; if (run > max_run) max_run = run; end else run = 0;
      if (bus.coef_ready && bus.coef_done) obs_q.push_back({bus.addr, bus.coef});
      if (bus.result_shift_ready) begin n_rs++; rs_seen = bus.result_shift_i; end
      if (bus.flush) n_flush++;
      if (int'(bus.coef_ready) + int'(bus.result_shift_ready) + int'(bus.flush) > 1) overlap++;
      if (done) begin n_done++; got_done = 1'b1; end
      xfer = src_valid && src_ready;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0; src_valid = 1'b0;
    vectors++;
    if (!got_done) begin
      miscompares++; $display("FAIL seq_done_timeout: no done within %0d cycles", cyc);
    end else if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL done_pulse_width: done=%0b busy=%0b one cycle after done, expected 0 0", done, busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    vectors++; if ({busy, done, error, src_ready} !== 4'b0) begin miscompares++; $display("FAIL reset_status: got %b expected 0000", {busy, done, error, src_ready}); end
    vectors++; if ({bus.coef_ready, bus.result_shift_ready, bus.flush} !== 3'b0) begin miscompares++; $display("FAIL reset_strobes: got %b expected 000", {bus.coef_ready, bus.result_shift_ready, bus.flush}); end
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (bus.addr !== '0 || bus.coef !== '0 || bus.result_shift_i !== '0) begin miscompares++; $display("FAIL reset_bus: addr=%0h coef=%0h shift=%0h expected 0", bus.addr, bus.coef, bus.result_shift_i); end
    vectors++; if (err_code !== 2'b00 || err_addr !== '0) begin miscompares++; $display("FAIL reset_err: code=%b addr=%0d expected 00 0", err_code, err_addr); end
    vectors++; if (dbg_state !== 3'd0 || busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle: state=%0d busy=%0b expected 0 0", dbg_state, busy); end
  endtask

  task automatic test_happy_path();
    exp_q.delete();
    for (int k = 0; k < 16; k++) exp_q.push_back({coef_id_w'(k), coef_width'(k * 3)});
    run_seq(5'd4, -1, 0, -1);
    vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL happy_writes: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin vectors++; if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL happy_write_%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end end
    vectors++; if (n_ready !== 32) begin miscompares++; $display("FAIL happy_ready_cycles: got %0d expected 32", n_ready); end
    vectors++; if (busy_cyc !== 84) begin miscompares++; $display("FAIL happy_cycles: got %0d expected 84", busy_cyc); end
    vectors++; if (rs_seen !== 5'd4 || n_rs !== 2) begin miscompares++; $display("FAIL happy_shift: got %0d/%0d cycles expected 4/2", rs_seen, n_rs); end
    vectors++; if (n_flush !== 1 || n_done !== 1) begin miscompares++; $display("FAIL happy_flush_done: got %0d %0d expected 1 1", n_flush, n_done); end
    vectors++; if (error !== 1'b0 || err_code !== 2'b00) begin miscompares++; $display("FAIL happy_error: got %0b %b expected 0 00", error, err_code); end
    vectors++; if (overlap !== 0) begin miscompares++; $display("FAIL happy_overlap: got %0d expected 0", overlap); end
  endtask

  task automatic test_source_stall();
    exp_q.delete();
    for (int k = 0; k < 16; k++) exp_q.push_back({coef_id_w'(k), coef_width'(k * 3)});
    run_seq(5'd4, 5, 7, -1);
    vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL stall_writes: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin vectors++; if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL stall_write_%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end end
    vectors++; if (busy_cyc !== 91) begin miscompares++; $display("FAIL stall_cycles: got %0d expected 91", busy_cyc); end
    vectors++; if (n_flush !== 1 || error !== 1'b0) begin miscompares++; $display("FAIL stall_end: flush=%0d error=%0b expected 1 0", n_flush, error); end
  endtask

  task automatic test_readback_fault();
    exp_q.delete();
    for (int k = 0; k < 10; k++) exp_q.push_back({coef_id_w'(k), coef_width'(k * 3)});
    bad_addr = 9;
    run_seq(5'd4, -1, 0, -1);
    bad_addr = -1;
    vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rbk_writes: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin vectors++; if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rbk_write_%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end end
    vectors++; if (error !== 1'b1 || err_code !== 2'b01 || err_addr !== 4'd9) begin miscompares++; $display("FAIL rbk_error: got %0b %b %0d expected 1 01 9", error, err_code, err_addr); end
    vectors++; if (n_flush !== 0 || n_rs !== 0 || n_done !== 1) begin miscompares++; $display("FAIL rbk_strobes: flush=%0d rs=%0d done=%0d expected 0 0 1", n_flush, n_rs, n_done); end
    vectors++; if (busy_cyc !== 51) begin miscompares++; $display("FAIL rbk_cycles: got %0d expected 51", busy_cyc); end
  endtask

  task automatic test_ack_timeout();
    noack_addr = 3;
    run_seq(5'd4, -1, 0, -1);
    noack_addr = -1;
    vectors++; if (obs_q.size() != 3) begin miscompares++; $display("FAIL tmo_writes: got %0d expected 3", obs_q.size()); end
    vectors++; if (max_run !== timeout || n_ready !== 21) begin miscompares++; $display("FAIL tmo_ready: run=%0d total=%0d expected %0d 21", max_run, n_ready, timeout); end
    vectors++; if (error !== 1'b1 || err_code !== 2'b10 || err_addr !== 4'd3) begin miscompares++; $display("FAIL tmo_error: got %0b %b %0d expected 1 10 3", error, err_code, err_addr); end
    vectors++; if (n_flush !== 0 || n_done !== 1 || busy_cyc !== 32) begin miscompares++; $display("FAIL tmo_end: flush=%0d done=%0d cycles=%0d expected 0 1 32", n_flush, n_done, busy_cyc); end
  endtask

  task automatic test_shift_mismatch();
    shift_corrupt = 1'b1; shift_corrupt_val = 5'd5;
    run_seq(5'd6, -1, 0, -1);
    shift_corrupt = 1'b0;
    vectors++; if (error !== 1'b1 || err_code !== 2'b11 || err_addr !== 4'd15) begin miscompares++; $display("FAIL shf_error: got %0b %b %0d expected 1 11 15", error, err_code, err_addr); end
    vectors++; if (n_flush !== 0 || n_done !== 1 || busy_cyc !== 83) begin miscompares++; $display("FAIL shf_end: flush=%0d done=%0d cycles=%0d expected 0 1 83", n_flush, n_done, busy_cyc); end
    run_seq(5'd6, -1, 0, -1);
    vectors++; if (err_first !== 1'b0) begin miscompares++; $display("FAIL shf_clear_on_start: got %0b expected 0", err_first); end
    vectors++; if (error !== 1'b0 || err_code !== 2'b00 || n_flush !== 1 || rs_seen !== 5'd6) begin miscompares++; $display("FAIL shf_rerun: err=%0b code=%b flush=%0d shift=%0d expected 0 00 1 6", error, err_code, n_flush, rs_seen); end
  endtask

  task automatic test_reset_mid_write();
    int cyc;
    bit saw;
    cyc = 0; saw = 1'b0;
    start = 1'b1; shift_val = 5'd4;
    @(negedge clk);
    start = 1'b0; src_valid = 1'b1; src_data = 24'h00ABCD;
    while (!(bus.addr == 4'd7 && bus.coef_ready) && cyc < 200) begin @(negedge clk); cyc++; end
    vectors++; if (cyc >= 200) begin miscompares++; $display("FAIL rmw_reach_addr7: got timeout expected addr 7 write"); end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if ({busy, done, src_ready, bus.coef_ready, bus.result_shift_ready, bus.flush} !== 6'b0) begin miscompares++; $display("FAIL rmw_strobes: got %b expected 000000", {busy, done, src_ready, bus.coef_ready, bus.result_shift_ready, bus.flush}); end
    vectors++; if (bus.addr !== '0 || bus.coef !== '0 || error !== 1'b0) begin miscompares++; $display("FAIL rmw_bus: addr=%0d coef=%0h err=%0b expected 0 0 0", bus.addr, bus.coef, error); end
    rst = 1'b0; src_valid = 1'b0;
    repeat (5) begin @(negedge clk); if (done || busy) saw = 1'b1; end
    vectors++; if (saw !== 1'b0) begin miscompares++; $display("FAIL rmw_no_done: got activity expected none"); end
    // Clean run with a second start pulse (shift 9) while busy; it must be ignored.
    exp_q.delete();
    for (int k = 0; k < 16; k++) exp_q.push_back({coef_id_w'(k), coef_width'(k * 3)});
    run_seq(5'd4, -1, 0, 10);
    vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL b2b_writes: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin vectors++; if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL b2b_write_%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end end
    vectors++; if (rs_seen !== 5'd4 || busy_cyc !== 84 || n_done !== 1) begin miscompares++; $display("FAIL b2b_ignore_start: shift=%0d cycles=%0d done=%0d expected 4 84 1", rs_seen, busy_cyc, n_done); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; start = 1'b0; shift_val = '0; src_valid = 1'b0; src_data = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_happy_path();
    test_source_stall();
    test_readback_fault();
    test_ack_timeout();
    test_shift_mismatch();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fir_coef_loader.md
Name: fir_coef_loader

Overview:
Master-side sequencer for the FIR filter's coefficient and result-shift configuration ports. It accepts a stream of coef_count coefficient words from the host command path. Each word is written at addresses 0..coef_count-1 through the addr/coef/coef_ready/coef_done handshake, then read back via coef_r and compared. After all coefficients pass, it programs and verifies the result shift, pulses flush to clear the filter delay lines, and reports done/error status to the host.

Parameters:
coef_width, 24, coefficient word width
coef_count, 16, number of coefficients loaded per sequence; coef_id_w = $clog2(coef_count)
max_shift, 32, result-shift range; max_shift_w = $clog2(max_shift)
timeout, 15, maximum cycles to wait for coef_done or result_shift_done before aborting

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  begin a load sequence; sampled only in IDLE
shift_val  in  max_shift_w  result shift to program; latched when start is accepted
src_valid  in  1  host coefficient word valid
src_data  in  coef_width  host coefficient word
src_ready  out  1  loader accepts a word; a transfer occurs when src_valid & src_ready
addr  out  coef_id_w  coefficient address to filter
coef  out  coef_width  coefficient value to filter
coef_ready  out  1  coefficient write strobe to filter
coef_done  in  1  filter write acknowledge
coef_r  in  coef_width  filter coefficient readout at addr, updated the cycle after coef_ready is low
result_shift_ready  out  1  result-shift write strobe
result_shift_i  out  max_shift_w  result shift value to filter
result_shift_done  in  1  filter result-shift acknowledge
result_shift  in  max_shift_w  filter result-shift readout
flush  out  1  one-cycle pulse clearing filter shift registers
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of sequence, on success or error
error  out  1  sticky; cleared when the next start is accepted
err_code  out  2  00 none, 01 coefficient readback mismatch, 10 ack timeout, 11 shift readback mismatch
err_addr  out  coef_id_w  address being processed when the error occurred

Behaviour:
- Reset: all outputs 0, state IDLE, address counter 0, timeout counter 0. Reset mid-sequence aborts immediately with no done pulse.
- IDLE: on start=1, latch shift_val, clear error/err_code/err_addr, set addr=0, go to FETCH. start while busy is ignored.
- FETCH: src_ready=1. On src_valid, latch src_data into coef and go to WRITE.
- WRITE: coef_ready=1, addr/coef held, timeout counter increments.
  - coef_done=1 sampled: go to READ. Earliest exit is the 2nd cycle in WRITE.
  - Counter reaches timeout: error=1, err_code=10, go to DONE.
- READ: coef_ready=0, addr held for one cycle so the filter loads coef_r.
- CMP: compare coef_r with coef.
  - Mismatch: error=1, err_code=01, err_addr=addr, go to DONE.
  - Match and addr == coef_count-1: go to SHIFT_WR.
  - Otherwise: addr+1, go to FETCH. addr never wraps within a sequence.
- Per-coefficient cost with src_valid held high: 5 cycles (FETCH 1, WRITE 2, READ 1, CMP 1).
- SHIFT_WR: result_shift_ready=1, result_shift_i = latched shift value.
  - result_shift_done=1 sampled: compare result_shift with the latched value. Mismatch: err_code=11, error=1, go to DONE. Match: go to FLUSH.
  - Timeout: err_code=10, err_addr=coef_count-1, go to DONE.
- FLUSH: flush=1 for exactly one cycle, then DONE.
- DONE: done=1 for one cycle, then IDLE.
- Timeout counter clears on entry to WRITE and on entry to SHIFT_WR.
- Strobes are never asserted simultaneously: coef_ready, result_shift_ready and flush are mutually exclusive.
- On error, no flush is issued. Coefficients already written stay in the filter.

Test Plan:
- Happy path: start with shift_val=4, src_valid held, src_data=k*3 for k=0..15, ideal filter model -> 16 writes at addr 0..15 with coef_ready 2 cycles each, result_shift_i=4, one flush pulse, done pulse, error=0, 5 cycles per coefficient.
- Source stall: src_valid low for 7 cycles before word 5 -> src_ready held high, addr stays 5, no coef_ready during stall, final values correct.
- Readback fault: model returns coef_r=0 at addr 9 after writing 0x00001B -> err_code=01, err_addr=9, done pulse, no flush, no writes at addr 10.
- Ack timeout: model never asserts coef_done at addr 3 -> coef_ready high for exactly timeout cycles, err_code=10, err_addr=3, done pulse.
- Shift mismatch: model stores result_shift=5 when shift_val=6 -> err_code=11, no flush; subsequent start clears error and a clean run passes.
- Reset mid-write at addr 7 with coef_ready=1 -> next cycle all outputs 0, busy=0, no done; start ignored while busy in the clean run.
